// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised accumulator CPU with valid/ready instruction fetch,
// internal data RAM, Z/C flags, conditional branches and halt.
module cpu_core_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] inst,
   input  logic              inst_valid,
   output logic              inst_ready,
   output logic              Y,
   output logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] MAR,
   output logic [DATA_W-1:0] MBR,
   output logic [DATA_W-1:0] ACC,
   output logic [7:0]        signal
);
   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
   state_t state, state_nxt;
   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic z, c;
   logic [3:0] op;
   logic [DATA_W-5:0] opnd;
   logic [DATA_W-1:0] imm, m, acc_nxt;
   logic [DATA_W:0] sum, dif;
   logic exec, ram_we, acc_we, c_we, c_nxt, jump;
   assign op = MBR[DATA_W-1 -: 4];
   assign opnd = MBR[DATA_W-5:0];
   assign imm = {4'b0, opnd};
   assign m = ram[MAR];
   assign sum = {1'b0, ACC} + {1'b0, m};
   assign dif = {1'b0, ACC} - {1'b0, m};
   assign exec = state == EXEC;
   assign inst_ready = state == FETCH;
   assign Y = z;
   assign ram_we = exec && op == 4'h3;
   assign c_we = exec && (op == 4'h4 || op == 4'h5);
   assign c_nxt = op == 4'h4 ? sum[DATA_W] : dif[DATA_W];
   assign jump = exec && (op == 4'hA || (op == 4'hB && z) || (op == 4'hC && c));
   assign signal = {c, jump, acc_we, ram_we, state == HALT, exec, state == DECODE, state == FETCH};
   always_comb begin
      acc_nxt = ACC;
      acc_we = exec;
      case (op)
         4'h1: acc_nxt = imm;
         4'h2: acc_nxt = m;
         4'h4: acc_nxt = sum[DATA_W-1:0];
         4'h5: acc_nxt = dif[DATA_W-1:0];
         4'h6: acc_nxt = ACC & m;
         4'h7: acc_nxt = ACC | m;
         4'h8: acc_nxt = ACC ^ m;
         4'h9: acc_nxt = ~ACC;
         default: acc_we = 1'b0;
      endcase
   end
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   state_nxt = inst_valid ? DECODE : FETCH;
         DECODE:  state_nxt = op == 4'hF ? HALT : EXEC;
         EXEC:    state_nxt = FETCH;
         default: state_nxt = HALT;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= FETCH;
      else state <= state_nxt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PC <= '0;
         MAR <= '0;
         MBR <= '0;
         ACC <= '0;
         z <= 1'b0;
         c <= 1'b0;
         for (int i = 0; i < 2**ADDR_W; i++) ram[i] <= '0;
      end else begin
         if (state == FETCH) MAR <= PC;
         if (state == FETCH && inst_valid) begin
            MBR <= inst;
            PC <= PC + ADDR_W'(1);
         end
         if (state == DECODE) MAR <= opnd[ADDR_W-1:0];
         if (exec && op == 4'h2) MBR <= m;
         if (acc_we) begin
            ACC <= acc_nxt;
            z <= acc_nxt == '0;
         end
         if (c_we) c <= c_nxt;
         if (ram_we) ram[MAR] <= ACC;
         if (jump) PC <= opnd[ADDR_W-1:0];
      end
   end
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed tests for cpu_core_param with hand-computed expectations.
module tb_cpu_core_param;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [7:0] inst = '0;
   logic inst_valid = 1'b0;
   logic inst_ready, Y;
   logic [3:0] PC, MAR;
   logic [7:0] MBR, ACC, signal;
   logic [7:0] exec_sig;
   logic [3:0] fetch_pc;
   int tests = 0;
   int fails = 0;

   cpu_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .Y(Y), .PC(PC), .MAR(MAR), .MBR(MBR),
      .ACC(ACC), .signal(signal)
   );

   always #5 clk = ~clk;

   task automatic run(input logic [7:0] i);
      int n = 0;
      while (!inst_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (inst_ready !== 1'b1) begin
         fails++;
         $display("FAIL run_ready inst=%h got inst_ready=%b want 1", i, inst_ready);
      end
      fetch_pc = PC;
      inst = i;
      inst_valid = 1'b1;
      @(posedge clk); #1;
      inst_valid = 1'b0;
      @(posedge clk); #1;
      exec_sig = signal;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      tests++;
      if ({PC, MAR, MBR, ACC, Y} !== '0) begin
         fails++;
         $display("FAIL reset_regs got PC=%h MAR=%h MBR=%h ACC=%h Y=%b want all 0", PC, MAR, MBR, ACC, Y);
      end
      tests++;
      if (signal !== 8'h01 || inst_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ctrl got signal=%h ready=%b want 01/1", signal, inst_ready);
      end
   endtask

   task automatic test_basic;
      run(8'h15);
      tests++;
      if (ACC !== 8'h05) begin fails++; $display("FAIL ldi got ACC=%h want 05", ACC); end
      run(8'h33);
      tests++;
      if (exec_sig[4] !== 1'b1) begin fails++; $display("FAIL sta_we got signal=%h want bit4 set", exec_sig); end
      run(8'h10);
      tests++;
      if (ACC !== 8'h00 || Y !== 1'b1) begin fails++; $display("FAIL ldi0 got ACC=%h Y=%b want 00/1", ACC, Y); end
      run(8'h43);
      tests++;
      if (ACC !== 8'h05 || Y !== 1'b0 || signal[7] !== 1'b0) begin
         fails++;
         $display("FAIL add got ACC=%h Y=%b C=%b want 05/0/0", ACC, Y, signal[7]);
      end
      tests++;
      if (PC !== 4'h4 || MBR !== 8'h43) begin fails++; $display("FAIL add_pc got PC=%h MBR=%h want 4/43", PC, MBR); end
   endtask

   task automatic test_carry;
      run(8'h1F);
      run(8'h30);
      for (int k = 0; k < 16; k++) run(8'h40);
      tests++;
      if (ACC !== 8'hFF || signal[7] !== 1'b0) begin
         fails++;
         $display("FAIL add16 got ACC=%h C=%b want FF/0", ACC, signal[7]);
      end
      run(8'h40);
      tests++;
      if (ACC !== 8'h0E || signal[7] !== 1'b1) begin
         fails++;
         $display("FAIL add17 got ACC=%h C=%b want 0E/1", ACC, signal[7]);
      end
      run(8'h10);
      run(8'h90);
      tests++;
      if (ACC !== 8'hFF) begin fails++; $display("FAIL not got ACC=%h want FF", ACC); end
      run(8'h30);
      run(8'h10);
      run(8'h50);
      tests++;
      if (ACC !== 8'h01 || signal[7] !== 1'b1 || Y !== 1'b0) begin
         fails++;
         $display("FAIL sub got ACC=%h C=%b Y=%b want 01/1/0", ACC, signal[7], Y);
      end
      run(8'hC9);
      tests++;
      if (PC !== 4'h9 || exec_sig[6] !== 1'b1) begin
         fails++;
         $display("FAIL jc got PC=%h jump=%b want 9/1", PC, exec_sig[6]);
      end
   endtask

   task automatic test_branch;
      run(8'h10);
      run(8'hB7);
      tests++;
      if (PC !== 4'h7 || exec_sig[6] !== 1'b1) begin
         fails++;
         $display("FAIL jz_taken got PC=%h jump=%b want 7/1", PC, exec_sig[6]);
      end
      run(8'h11);
      run(8'hB2);
      tests++;
      if (PC !== fetch_pc + 4'h1 || exec_sig[6] !== 1'b0) begin
         fails++;
         $display("FAIL jz_not got PC=%h jump=%b want %h/0", PC, exec_sig[6], fetch_pc + 4'h1);
      end
      run(8'hAF);
      run(8'hAF);
      tests++;
      if (fetch_pc !== 4'hF || PC !== 4'hF) begin
         fails++;
         $display("FAIL jmp_f got fetch=%h PC=%h want F/F", fetch_pc, PC);
      end
      run(8'h00);
      tests++;
      if (PC !== 4'h0) begin fails++; $display("FAIL pc_wrap got PC=%h want 0", PC); end
   endtask

   task automatic test_back_to_back;
      run(8'h19);
      run(8'h35);
      run(8'h25);
      tests++;
      if (ACC !== 8'h09 || MBR !== 8'h09) begin
         fails++;
         $display("FAIL sta_lda got ACC=%h MBR=%h want 09/09", ACC, MBR);
      end
   endtask

   task automatic test_stall;
      logic [3:0] pc0;
      logic [7:0] mbr0, acc0;
      @(posedge clk); #1;
      pc0 = PC; mbr0 = MBR; acc0 = ACC;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         tests++;
         if (PC !== pc0 || MAR !== pc0 || MBR !== mbr0 || ACC !== acc0 || inst_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall%0d got PC=%h MAR=%h MBR=%h ACC=%h rdy=%b want %h/%h/%h/%h/1",
                     k, PC, MAR, MBR, ACC, inst_ready, pc0, pc0, mbr0, acc0);
         end
      end
      inst = 8'h00;
      inst_valid = 1'b1;
      @(posedge clk); #1;
      inst_valid = 1'b0;
      tests++;
      if (signal[1:0] !== 2'b10 || PC !== pc0 + 4'h1) begin
         fails++;
         $display("FAIL stall_go got signal=%h PC=%h want DECODE/%h", signal, PC, pc0 + 4'h1);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_halt;
      logic [3:0] pc0;
      logic [7:0] acc0;
      run(8'hF0);
      tests++;
      if (signal !== 8'h88 || inst_ready !== 1'b0) begin
         fails++;
         $display("FAIL halt got signal=%h rdy=%b want 88/0", signal, inst_ready);
      end
      pc0 = PC; acc0 = ACC;
      inst = 8'h15;
      inst_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         tests++;
         if (signal !== 8'h88 || PC !== pc0 || ACC !== acc0 || inst_ready !== 1'b0) begin
            fails++;
            $display("FAIL halt_hold%0d got signal=%h PC=%h ACC=%h want 88/%h/%h", k, signal, PC, ACC, pc0, acc0);
         end
      end
      inst_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      test_reset;
      run(8'h17);
      inst = 8'h32;
      inst_valid = 1'b1;
      @(posedge clk); #1;
      inst_valid = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (signal[4] !== 1'b1) begin fails++; $display("FAIL mid_exec got signal=%h want bit4 set", signal); end
      reset = 1'b0;
      #1;
      tests++;
      if (PC !== 4'h0 || ACC !== 8'h00 || signal !== 8'h01) begin
         fails++;
         $display("FAIL mid_reset got PC=%h ACC=%h signal=%h want 0/00/01", PC, ACC, signal);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      run(8'h22);
      tests++;
      if (ACC !== 8'h00 || MBR !== 8'h00 || Y !== 1'b1) begin
         fails++;
         $display("FAIL mid_ram got ACC=%h MBR=%h Y=%b want 00/00/1", ACC, MBR, Y);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_carry;
      test_branch;
      test_back_to_back;
      test_stall;
      test_halt;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
